// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Brief    : Instruction-fetch stage for the 5-stage MIPS64 pipeline. Owns the
//            fetch PC, issues single-outstanding word fetches to a
//            variable-latency instruction memory, buffers the returned words
//            in a small FIFO and presents the head entry to ID. Redirects
//            flush the queue and discard any in-flight fetch.
// Revision : 1.0 - initial release
// ============================================================================

package if_fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc4;
        logic [63:0] pc;
    } IF_regs_t;
endpackage

module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output IF_regs_t    IF_regs
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w:0]   c_depth = (c_cnt_w + 1)'(DEPTH);

    // IDLE: nothing outstanding; BUSY: response will be kept;
    // DROP: response will be thrown away (a redirect overtook it).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t               r_state;
    logic [63:0]          r_fetch_pc;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [31:0]          r_inst_mem [DEPTH];
    logic [63:0]          r_pc_mem   [DEPTH];

    logic                 w_push;
    logic                 w_pop;
    logic [c_cnt_w:0]     w_level;
    logic                 w_space;
    logic [63:0]          w_pc_plus4;
    logic                 w_unused_ok;

    // The low bits of a redirect target are architecturally ignored.
    assign w_unused_ok = ^redirect_pc[1:0];

    assign w_pc_plus4 = r_fetch_pc + 64'd4;
    assign if_valid   = !reset && (r_count != '0);
    assign w_push     = (r_state == ST_BUSY) && imem_valid && !redirect;
    assign w_pop      = if_valid && !stall && !redirect;

    // Occupancy after this cycle; a new fetch only goes out if it will have a slot.
    assign w_level = {1'b0, r_count}
                   + {{c_cnt_w{1'b0}}, w_push}
                   - {{c_cnt_w{1'b0}}, w_pop};
    assign w_space = (w_level < c_depth);

    assign imem_req  = !reset && !redirect && w_space
                     && ((r_state == ST_IDLE) || w_push);
    // On a back-to-back issue the PC register has not yet advanced.
    assign imem_addr = w_push ? w_pc_plus4 : r_fetch_pc;

    // Fetch FSM, fetch PC and queue pointers; reset beats redirect beats push/pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[63:2], 2'b00};
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            // A fetch still in flight must be drained before restarting.
            if ((r_state != ST_IDLE) && !imem_valid) begin
                r_state <= ST_DROP;
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            r_count <= w_level[c_cnt_w-1:0];
            if (w_push) begin
                r_fetch_pc <= w_pc_plus4;
                r_wr_ptr   <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case (r_state)
                ST_IDLE: if (imem_req)   r_state <= ST_BUSY;
                ST_BUSY: if (w_push)     r_state <= imem_req ? ST_BUSY : ST_IDLE;
                ST_DROP: if (imem_valid) r_state <= ST_IDLE;
                default:                 r_state <= ST_IDLE;
            endcase
        end
    end

    // Queue storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_inst_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    // Head entry to ID, or an all-zero NOP bubble when nothing is queued.
    always_comb begin
        IF_regs = '0;
        if (if_valid) begin
            IF_regs.inst = r_inst_mem[r_rd_ptr];
            IF_regs.pc   = r_pc_mem[r_rd_ptr];
            IF_regs.pc4  = r_pc_mem[r_rd_ptr] + 64'd4;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Self-checking bench for if_fetch_queue with a single-outstanding
//            variable-latency memory model and an expected-output queue.
// Revision : 1.0 - initial release
// ============================================================================

module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam logic [63:0] RPC = 64'h100;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    IF_regs_t    IF_regs;

    if_fetch_queue #(.RESET_PC(RPC), .DEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .if_valid    (if_valid),
        .IF_regs     (IF_regs)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    IF_regs_t sb[$];

    bit          mem_pend;
    bit          mem_drop;
    int          mem_cnt;
    int          mem_lat;
    logic [63:0] mem_addr;
    bit          stray;
    logic [63:0] exp_addr;

    logic        s_req;
    logic [63:0] s_addr;
    logic        s_valid;
    IF_regs_t    s_regs;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic IF_regs_t mk(input logic [63:0] pc);
        IF_regs_t e;
        e.inst = inst_of(pc);
        e.pc4  = pc + 64'd4;
        e.pc   = pc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample mid-cycle, check, update model.
    task automatic cyc(input bit rst, input bit rd, input logic [63:0] rpc, input bit stl);
        bit resp;
        bit resp_drop;
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        stall       = stl;
        imem_valid  = 1'b0;
        imem_rdata  = $urandom();
        resp        = 1'b0;
        resp_drop   = mem_drop;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                resp     = 1'b1;
                mem_pend = 1'b0;
            end
        end
        if (resp) begin
            imem_valid = 1'b1;
            imem_rdata = inst_of(mem_addr);
        end else if (stray) begin
            imem_valid = 1'b1;
            stray      = 1'b0;
        end
        #3;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = if_valid;
        s_regs  = IF_regs;
        if (rst) begin
            chk("rst_req", s_req, 1'b0);
            chk("rst_valid", s_valid, 1'b0);
            chk("rst_regs", s_regs, '0);
        end else begin
            chk("valid", s_valid, (sb.size() != 0));
            if (sb.size() != 0) chk("head", s_regs, sb[0]);
            else                chk("bubble", s_regs, '0);
            if (rd) chk("redirect_no_req", s_req, 1'b0);
            if (sb.size() != 0 && !stl && !rd) void'(sb.pop_front());
            if (resp && !resp_drop && !rd) sb.push_back(mk(mem_addr));
            if (s_req) begin
                chk("one_outstanding", mem_pend, 1'b0);
                chk("req_addr", s_addr, exp_addr);
                mem_pend = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = s_addr;
                mem_drop = 1'b0;
                exp_addr = exp_addr + 64'd4;
            end
        end
        if (rst) begin
            sb.delete();
            exp_addr = RPC;
            mem_pend = 1'b0;
            mem_drop = 1'b0;
        end else if (rd) begin
            sb.delete();
            exp_addr = {rpc[63:2], 2'b00};
            if (mem_pend) mem_drop = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b0);
            found = s_req;
        end
        chk({tag, "_timeout"}, found, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b0);
            found = s_valid;
        end
        chk({tag, "_timeout"}, found, 1'b1);
    endtask

    task automatic wait_resp_next(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            found = mem_pend && (mem_cnt == 1);
            if (!found) cyc(1'b0, 1'b0, 64'h0, 1'b0);
        end
        chk({tag, "_timeout"}, found, 1'b1);
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_valid = 1'b0; imem_rdata = '0;
        mem_pend = 1'b0; mem_drop = 1'b0; mem_cnt = 0; mem_lat = 1;
        mem_addr = '0; stray = 1'b0; exp_addr = RPC;
        @(posedge clock);
        #1;

        // Startup with 1-cycle memory
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t1_req0", s_req, 1'b1);
        chk("t1_addr0", s_addr, 64'h100);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t1_addr1", s_addr, 64'h104);
        chk("t1_valid1", s_valid, 1'b0);

        // Stall for 6 cycles from the first valid
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t1_first", s_regs, mk(64'h100));
        chk("t2_req_full", s_req, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 64'h0, 1'b1);
            chk("t2_stall_req", s_req, 1'b0);
            chk("t2_stall_pc", s_regs.pc, 64'h100);
        end
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t2_rel_pc0", s_regs.pc, 64'h100);
        chk("t2_rel_addr", s_addr, 64'h108);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t2_rel_pc1", s_regs.pc, 64'h104);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t2_rel_pc2", s_regs.pc, 64'h108);

        // 3-cycle memory, redirect during the wait
        mem_lat = 3;
        wait_req("t3_req");
        cyc(1'b0, 1'b1, 64'h2000, 1'b0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t3_drop_noreq1", s_req, 1'b0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t3_drop_noreq2", s_req, 1'b0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t3_new_req", s_req, 1'b1);
        chk("t3_new_addr", s_addr, 64'h2000);
        wait_valid("t3_valid");
        chk("t3_first_pc", s_regs.pc, 64'h2000);

        // Redirect coincident with a response
        wait_resp_next("t4_resp");
        cyc(1'b0, 1'b1, 64'h3003, 1'b0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t4_req", s_req, 1'b1);
        chk("t4_addr", s_addr, 64'h3000);
        chk("t4_valid", s_valid, 1'b0);

        // Redirect with queue full and stall high
        mem_lat = 1;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t5_full_valid", s_valid, 1'b1);
        chk("t5_full_noreq", s_req, 1'b0);
        chk("t5_full_pc", s_regs.pc, 64'h3000);
        cyc(1'b0, 1'b1, 64'h4000, 1'b1);
        chk("t5_rd_valid", s_valid, 1'b1);
        cyc(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t5_after_valid", s_valid, 1'b0);
        chk("t5_after_req", s_req, 1'b1);
        chk("t5_after_addr", s_addr, 64'h4000);

        // Fetch PC wrap at the top of the address space
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        wait_req("t6_req");
        chk("t6_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t6_addr_wrap", s_addr, 64'h0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t6_pc", s_regs.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_pc4", s_regs.pc4, 64'h0);

        // Reset while BUSY, then a stray late response
        mem_lat = 3;
        wait_req("t7_req");
        cyc(1'b1, 1'b0, 64'h0, 1'b0);
        stray = 1'b1;
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t7_req", s_req, 1'b1);
        chk("t7_addr", s_addr, RPC);
        chk("t7_valid0", s_valid, 1'b0);
        cyc(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t7_valid1", s_valid, 1'b0);
        wait_valid("t7_first");
        chk("t7_first_pc", s_regs.pc, RPC);

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 64'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
